// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, execute redirect,
// and the valid/ready hand-off to decode.
// master: the fetch unit's view. slave: the surrounding memory/execute/decode side.
interface ifu_fetch_if #(
  parameter int unsigned XLEN = 64
) ();
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_pc;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
           out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
           out_ready
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the PC, keeps at most one instruction-memory
// request outstanding, and registers each returned word with its PC for decode.
// Redirects from execute win over every other event; a fetch already in flight
// is absorbed through the drop flag.
// Optional: define IFU_MISALIGN_CHECK_EN to add the fetch_misalign output and a
// FAULT state entered on redirects to non word-aligned targets.
module ifu_fetch #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] PC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic           clk,
  input  logic           rst_n,
`ifdef IFU_MISALIGN_CHECK_EN
  output logic           fetch_misalign,
`endif
  ifu_fetch_if.master    fetch
);

`ifdef IFU_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {StReq, StWait, StHold, StFault} state_e;
`else
  typedef enum logic [1:0] {StReq, StWait, StHold} state_e;
`endif

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_inst_q, out_inst_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;

  logic [XLEN-1:0] redir_tgt;
  logic            redir_bad;
  state_e          redir_st;   // where a redirect lands when no fetch is left in flight
  state_e          dropped_st; // where a discarded response lands

`ifdef IFU_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  // Misaligned targets are kept verbatim so the faulting PC stays visible.
  always_comb begin
    redir_tgt  = fetch.redirect_pc;
    redir_bad  = |fetch.redirect_pc[1:0];
    redir_st   = redir_bad ? StFault : StReq;
    dropped_st = misalign_q ? StFault : StReq;
  end

  assign fetch_misalign = misalign_q;
`else
  // Low target bits are forced to zero: every fetch address is word aligned.
  always_comb begin
    redir_tgt  = fetch.redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};
    redir_bad  = 1'b0;
    redir_st   = StReq;
    dropped_st = StReq;
  end
`endif

  // Next-state: redirect first, then the normal REQ -> WAIT -> HOLD cycle.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
`ifdef IFU_MISALIGN_CHECK_EN
    misalign_d  = misalign_q;
`endif
    if (fetch.redirect_valid) begin
      pc_d   = redir_tgt;
      drop_d = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
      misalign_d = redir_bad;
`endif
      case (state_q)
        StReq: begin
          if (fetch.imem_req_ready) begin
            // Request went out this cycle; its response must be swallowed.
            drop_d  = 1'b1;
            state_d = StWait;
          end else begin
            state_d = redir_st;
          end
        end
        StWait: begin
          if (fetch.imem_resp_valid) begin
            state_d = redir_st;
          end else begin
            drop_d  = 1'b1;
            state_d = StWait;
          end
        end
        StHold: begin
          out_valid_d = 1'b0;
          state_d     = redir_st;
        end
        default: state_d = redir_st;
      endcase
    end else begin
      case (state_q)
        StReq: begin
          if (fetch.imem_req_ready) state_d = StWait;
        end
        StWait: begin
          if (fetch.imem_resp_valid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = dropped_st;
            end else begin
              out_inst_d  = fetch.imem_resp_data;
              out_pc_d    = pc_q;
              pc_d        = pc_q + {{(XLEN-3){1'b0}}, 3'd4};
              out_valid_d = 1'b1;
              state_d     = StHold;
            end
          end
        end
        StHold: begin
          if (fetch.out_ready) begin
            out_valid_d = 1'b0;
            state_d     = StReq;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StReq;
      pc_q        <= PC_RESET;
      drop_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_inst_q  <= 32'h0;
      out_pc_q    <= PC_RESET;
`ifdef IFU_MISALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
`ifdef IFU_MISALIGN_CHECK_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  // Request is masked only by reset itself; otherwise purely registered.
  assign fetch.imem_req_valid = (state_q == StReq) && rst_n;
  assign fetch.imem_req_addr  = pc_q;
  assign fetch.out_valid      = out_valid_q;
  assign fetch.out_inst       = out_inst_q;
  assign fetch.out_pc         = out_pc_q;

endmodule
